// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared ALU op/flag encodings and shift-sequencer helper functions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

   typedef enum logic [4:0] {
      ALUOP_AND = 5'd0,
      ALUOP_OR  = 5'd1,
      ALUOP_XOR = 5'd2,
      ALUOP_ADD = 5'd3,
      ALUOP_ADC = 5'd4,
      ALUOP_SUB = 5'd5,
      ALUOP_SBB = 5'd6,
      ALUOP_CMP = 5'd7,
      ALUOP_ROL = 5'd8,
      ALUOP_ROR = 5'd9,
      ALUOP_RCL = 5'd10,
      ALUOP_RCR = 5'd11,
      ALUOP_SHL = 5'd12,
      ALUOP_SHR = 5'd13,
      ALUOP_SAR = 5'd14,
      ALUOP_NOT = 5'd15
   } AluOp;

   typedef enum logic [2:0] {
      FLAG_CY = 3'd0,
      FLAG_P  = 3'd1,
      FLAG_AC = 3'd2,
      FLAG_Z  = 3'd3,
      FLAG_S  = 3'd4,
      FLAG_V  = 3'd5
   } AluFlags;

   localparam int         BYTE_MSB = 7;
   localparam int         WORD_MSB = 15;
   localparam logic [4:0] CNT_MASK = 5'h1F;

   function automatic logic is_rotate_op(input logic [4:0] op);
      return (op == ALUOP_ROL) || (op == ALUOP_ROR);
   endfunction

   function automatic logic is_shift_op(input logic [4:0] op);
      return is_rotate_op(op) || (op == ALUOP_SHL) || (op == ALUOP_SHR);
   endfunction

   // Flags an op is allowed to overwrite; everything else keeps its PSW value.
   function automatic logic [5:0] step_flag_mask(input logic [4:0] op);
      logic [5:0] m;
      m = '0;
      if (is_rotate_op(op)) begin
         m[FLAG_CY] = 1'b1;
         m[FLAG_V]  = 1'b1;
      end else if ((op == ALUOP_SHL) || (op == ALUOP_SHR)) begin
         m[FLAG_CY] = 1'b1;
         m[FLAG_V]  = 1'b1;
         m[FLAG_Z]  = 1'b1;
         m[FLAG_S]  = 1'b1;
         m[FLAG_P]  = 1'b1;
      end
      return m;
   endfunction

   // A rotate that reduces to zero still runs a full turn so CY is refreshed.
   function automatic logic [4:0] eff_count(input logic [4:0] op, input logic size,
                                            input logic [4:0] cnt5, input logic reduce);
      logic [4:0] red;
      if (reduce && is_rotate_op(op)) begin
         red = size ? {1'b0, cnt5[3:0]} : {2'b00, cnt5[2:0]};
         if ((red == 5'd0) && (cnt5 != 5'd0))
            red = size ? 5'd16 : 5'd8;
         return red;
      end
      return cnt5;
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module   : alu
// Purpose  : Combinational 8/16-bit ALU; shift/rotate ops move by one bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu
   import alu_pkg::*;
(
   input  logic [4:0]  op,
   input  logic        size,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] r,
   output logic [5:0]  flags
);

   logic [15:0] res;
   logic [16:0] wide;
   logic        cy;
   logic        v;
   logic        ac;
   logic        a_top;
   logic        b_top;
   logic        r_top;

   always_comb begin
      res   = '0;
      wide  = '0;
      cy    = 1'b0;
      v     = 1'b0;
      ac    = 1'b0;
      a_top = size ? a[WORD_MSB] : a[BYTE_MSB];
      b_top = size ? b[WORD_MSB] : b[BYTE_MSB];
      case (AluOp'(op))
         ALUOP_AND: res = a & b;
         ALUOP_OR:  res = a | b;
         ALUOP_XOR: res = a ^ b;
         ALUOP_NOT: res = ~a;
         ALUOP_ADD: begin
            wide = size ? ({1'b0, a} + {1'b0, b}) : ({9'd0, a[7:0]} + {9'd0, b[7:0]});
            res  = wide[15:0];
            cy   = size ? wide[16] : wide[8];
            ac   = a[4] ^ b[4] ^ wide[4];
         end
         ALUOP_SUB: begin
            wide = size ? ({1'b0, a} - {1'b0, b}) : ({9'd0, a[7:0]} - {9'd0, b[7:0]});
            res  = wide[15:0];
            cy   = size ? wide[16] : wide[8];
            ac   = a[4] ^ b[4] ^ wide[4];
         end
         ALUOP_SHL: begin
            res = {a[14:0], 1'b0};
            cy  = a_top;
         end
         ALUOP_SHR: begin
            res = size ? {1'b0, a[15:1]} : {9'd0, a[7:1]};
            cy  = a[0];
         end
         ALUOP_ROL: begin
            res = size ? {a[14:0], a[15]} : {8'h00, a[6:0], a[7]};
            cy  = a_top;
         end
         ALUOP_ROR: begin
            res = size ? {a[0], a[15:1]} : {8'h00, a[0], a[7:1]};
            cy  = a[0];
         end
         default: res = a;
      endcase

      if (!size)
         res[15:8] = 8'h00;
      r_top = size ? res[WORD_MSB] : res[BYTE_MSB];

      case (AluOp'(op))
         ALUOP_ADD:            v = (a_top == b_top) && (r_top != a_top);
         ALUOP_SUB:            v = (a_top != b_top) && (r_top != a_top);
         ALUOP_SHL, ALUOP_ROL: v = r_top ^ cy;
         ALUOP_SHR:            v = a_top;
         ALUOP_ROR:            v = r_top ^ (size ? res[14] : res[6]);
         default:              v = 1'b0;
      endcase
   end

   assign r              = res;
   assign flags[FLAG_CY] = cy;
   assign flags[FLAG_P]  = ~^res[7:0];
   assign flags[FLAG_AC] = ac;
   assign flags[FLAG_Z]  = size ? (res == 16'h0000) : (res[7:0] == 8'h00);
   assign flags[FLAG_S]  = r_top;
   assign flags[FLAG_V]  = v;

endmodule

`default_nettype wire

// File: rtl/alu_shift_sequencer.sv
// ============================================================================
// Module   : alu_shift_sequencer
// Purpose  : Runs counted shifts/rotates as one single-bit ALU step per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_shift_sequencer
   import alu_pkg::*;
#(
   parameter bit ROT_REDUCE = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [4:0]  op,
   input  logic        size,
   input  logic [15:0] operand,
   input  logic [7:0]  count,
   input  logic [5:0]  flags_in,
   output logic        busy,
   output logic        done,
   output logic        illegal,
   output logic [15:0] result,
   output logic [5:0]  flags_out,
   output logic [4:0]  alu_op,
   output logic        alu_size,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   input  logic [15:0] alu_r,
   input  logic [5:0]  alu_flags
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_STEP = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

   logic [1:0]  state;
   logic [15:0] acc;
   logic [4:0]  rem;
   logic [5:0]  flag_q;
   logic [4:0]  op_q;
   logic        size_q;

   logic [4:0]  cnt5;
   logic [4:0]  start_cnt;
   logic        start_ok;
   logic [5:0]  flag_mask;
   logic [5:0]  flags_next;
   logic [15:0] acc_next;
   logic        in_step;
   logic        unused_count_hi;

   assign unused_count_hi = ^count[7:5];
   assign cnt5            = count[4:0] & CNT_MASK;
   assign start_cnt       = eff_count(op, size, cnt5, ROT_REDUCE);
   assign start_ok        = is_shift_op(op);

   assign flag_mask  = step_flag_mask(op_q);
   assign flags_next = (flag_q & ~flag_mask) | (alu_flags & flag_mask);
   // Byte mode never touches the upper half of the accumulator.
   assign acc_next   = size_q ? alu_r : {acc[15:8], alu_r[7:0]};

   assign in_step  = (state == ST_STEP);
   assign alu_op   = in_step ? op_q : ALUOP_AND;
   assign alu_size = in_step ? size_q : 1'b0;
   assign alu_a    = in_step ? (size_q ? acc : {8'h00, acc[7:0]}) : 16'h0000;
   assign alu_b    = in_step ? 16'd1 : 16'd0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         acc       <= '0;
         rem       <= '0;
         flag_q    <= '0;
         op_q      <= '0;
         size_q    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         illegal   <= 1'b0;
         result    <= '0;
         flags_out <= '0;
      end else begin
         done    <= 1'b0;
         illegal <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  acc    <= operand;
                  flag_q <= flags_in;
                  op_q   <= op;
                  size_q <= size;
                  rem    <= start_cnt;
                  busy   <= 1'b1;
                  if (start_ok && (start_cnt != 5'd0)) begin
                     state <= ST_STEP;
                  end else begin
                     state     <= ST_FIN;
                     done      <= 1'b1;
                     illegal   <= ~start_ok;
                     result    <= operand;
                     flags_out <= flags_in;
                  end
               end
            end
            ST_STEP: begin
               acc    <= acc_next;
               flag_q <= flags_next;
               rem    <= rem - 5'd1;
               if (rem == 5'd1) begin
                  state     <= ST_FIN;
                  done      <= 1'b1;
                  result    <= acc_next;
                  flags_out <= flags_next;
               end
            end
            ST_FIN: begin
               // A start arriving alongside done is dropped; the requester retries.
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_shift_sequencer.sv
// ============================================================================
// Module   : tb_alu_shift_sequencer
// Purpose  : Directed self-checking bench for alu_shift_sequencer driving alu.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_shift_sequencer;
   import alu_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [4:0]  op;
   logic        size;
   logic [15:0] operand;
   logic [7:0]  count;
   logic [5:0]  flags_in;
   logic        busy;
   logic        done;
   logic        illegal;
   logic [15:0] result;
   logic [5:0]  flags_out;
   logic [4:0]  alu_op;
   logic        alu_size;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [15:0] alu_r;
   logic [5:0]  alu_flags;

   int n_checks = 0;
   int n_fail   = 0;

   alu_shift_sequencer #(.ROT_REDUCE(1'b1)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .size(size),
      .operand(operand), .count(count), .flags_in(flags_in),
      .busy(busy), .done(done), .illegal(illegal), .result(result),
      .flags_out(flags_out), .alu_op(alu_op), .alu_size(alu_size),
      .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r), .alu_flags(alu_flags)
   );

   alu u_alu (
      .op(alu_op), .size(alu_size), .a(alu_a), .b(alu_b),
      .r(alu_r), .flags(alu_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [4:0] o, input logic s, input logic [15:0] opd,
                         input logic [7:0] c, input logic [5:0] fi);
      @(negedge clk);
      op = o; size = s; operand = opd; count = c; flags_in = fi; start = 1'b1;
      @(negedge clk);
      start = 1'b0; op = ALUOP_XOR; size = ~s; operand = 16'hDEAD; count = 8'hFF; flags_in = 6'h2A;
   endtask

   task automatic wait_done(inout int lat);
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [4:0] o, input logic s,
                         input logic [15:0] opd, input logic [7:0] c, input logic [5:0] fi,
                         input int exp_lat, input logic [15:0] exp_r,
                         input logic [5:0] exp_f, input logic exp_ill);
      int lat;
      launch(o, s, opd, c, fi);
      lat = 1;
      wait_done(lat);
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_result"},  32'(result), 32'(exp_r));
      check({tag, "_flags"},   32'(flags_out), 32'(exp_f));
      check({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
      check({tag, "_busy"},    32'(busy), 32'd1);
      @(negedge clk);
      check({tag, "_after"},   32'({busy, done, illegal}), 32'd0);
   endtask

   initial begin
      int lat;
      int pulses;
      reset = 1'b1; start = 1'b0; op = '0; size = 1'b0;
      operand = '0; count = '0; flags_in = '0;
      repeat (2) @(negedge clk);
      check("reset_ctrl",   32'({busy, done, illegal}), 32'd0);
      check("reset_result", 32'({flags_out, result}), 32'd0);
      check("reset_alu",    32'({alu_op, alu_size, alu_a, alu_b}), 32'd0);
      reset = 1'b0;

      // flag order {V,S,Z,AC,P,CY}
      run_op("shl_w",  ALUOP_SHL, 1'b1, 16'h8001, 8'd1,  6'h04, 2,  16'h0002, 6'h25, 1'b0);
      run_op("shr_b",  ALUOP_SHR, 1'b0, 16'hAB81, 8'd3,  6'h3F, 4,  16'hAB10, 6'h04, 1'b0);
      run_op("rol_b9", ALUOP_ROL, 1'b0, 16'h0080, 8'd9,  6'h00, 2,  16'h0001, 6'h21, 1'b0);
      run_op("rol_w16",ALUOP_ROL, 1'b1, 16'h8001, 8'd16, 6'h3C, 17, 16'h8001, 6'h1D, 1'b0);
      run_op("zero",   ALUOP_SHL, 1'b1, 16'h1234, 8'h20, 6'h15, 1,  16'h1234, 6'h15, 1'b0);
      run_op("mask",   ALUOP_SHR, 1'b1, 16'h0004, 8'h21, 6'h3F, 2,  16'h0002, 6'h04, 1'b0);
      run_op("ill",    ALUOP_ADD, 1'b1, 16'h5555, 8'd3,  6'h2A, 1,  16'h5555, 6'h2A, 1'b1);

      // Second start while busy must be ignored.
      launch(ALUOP_SHL, 1'b1, 16'h0001, 8'd4, 6'h00);
      lat = 1;
      @(negedge clk);
      lat++;
      op = ALUOP_ROR; size = 1'b1; operand = 16'hFFFF; count = 8'd1; start = 1'b1;
      @(negedge clk);
      lat++;
      start = 1'b0;
      wait_done(lat);
      check("busy_start_latency", 32'(lat), 32'd5);
      check("busy_start_result",  32'(result), 32'h0010);
      check("busy_start_flags",   32'(flags_out), 32'h00);
      pulses = 0;
      repeat (4) begin
         @(negedge clk);
         if (busy || done) pulses++;
      end
      check("busy_start_no_rerun", 32'(pulses), 32'd0);

      // Reset in cycle 2 of a 5-step SHL aborts without done.
      launch(ALUOP_SHL, 1'b1, 16'h0001, 8'd5, 6'h00);
      @(negedge clk);
      check("mid_alu_a",  32'(alu_a), 32'h0002);
      check("mid_alu_op", 32'(alu_op), 32'(ALUOP_SHL));
      reset = 1'b1;
      #1;
      check("abort_ctrl",   32'({busy, done, illegal}), 32'd0);
      check("abort_result", 32'({flags_out, result}), 32'd0);
      check("abort_alu",    32'({alu_op, alu_size, alu_a, alu_b}), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      pulses = 0;
      repeat (8) begin
         @(negedge clk);
         if (done || busy) pulses++;
      end
      check("abort_no_done", 32'(pulses), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
